// File: rtl/lfsr_pkg.sv
// Shared constants and helpers for the parametrised LFSR generator:
// digit count, hex glyph table and default tap masks.
package lfsr_pkg;

    localparam logic [3:0] TAPS_W4 = 4'b0011;
    localparam logic [7:0] TAPS_W8 = 8'b0001_1101;

    // Active-low gfedcba glyphs, index 0 is the rightmost entry.
    localparam logic [15:0][6:0] HEX_GLYPH = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic int unsigned ndig(input int unsigned width);
        return (width + 32'd3) / 32'd4;
    endfunction

endpackage

// File: rtl/hex7seg.sv
// One hex digit to active-low seven-segment pattern (bit 0 = a ... bit 6 = g).
module hex7seg
    import lfsr_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_c
);

    assign seg_c = HEX_GLYPH[nib_i];

endmodule

// File: rtl/lfsr_gen.sv
// Fibonacci LFSR with seed load, free-run/step modes, zero lock-up recovery,
// period measurement against a reference state, and hex segment readout.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_W8),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
    localparam int unsigned     NDIG  = ndig(WIDTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                mode,
    input  logic                step,
    input  logic                load,
    input  logic [WIDTH-1:0]    load_val,
    output logic [WIDTH-1:0]    state,
    output logic [7*NDIG-1:0]   seg,
    output logic [WIDTH-1:0]    period,
    output logic                period_valid,
    output logic                lockup
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             period_valid_q, period_valid_d;
    logic             lockup_q, lockup_d;
    logic             step_prev_q;

    logic             fb_c;
    logic             adv_c;
    logic [WIDTH-1:0] nxt_c;
    logic [WIDTH-1:0] load_v_c;

    // Priority: load, zero recovery, advance, hold.
    always_comb begin
        state_d        = state_q;
        ref_d          = ref_q;
        cnt_d          = cnt_q;
        period_d       = period_q;
        period_valid_d = period_valid_q;
        lockup_d       = 1'b0;

        fb_c     = ^(state_q & TAPS);
        nxt_c    = {fb_c, state_q[WIDTH-1:1]};
        adv_c    = en & (mode ? (step & ~step_prev_q) : 1'b1);
        load_v_c = (load_val == '0) ? ONE : load_val;

        if (load) begin
            state_d        = load_v_c;
            ref_d          = load_v_c;
            cnt_d          = '0;
            period_valid_d = 1'b0;
            lockup_d       = (load_val == '0);
        end else if (state_q == '0) begin
            state_d  = ONE;
            lockup_d = 1'b1;
        end else if (adv_c) begin
            state_d = nxt_c;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + ONE;
            end
            // A saturated counter cannot represent the lap, so keep the old result.
            if (nxt_c == ref_q) begin
                cnt_d = '0;
                if (cnt_q != CNT_MAX) begin
                    period_d       = cnt_q + ONE;
                    period_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= SEED;
            ref_q          <= SEED;
            cnt_q          <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            lockup_q       <= 1'b0;
            step_prev_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            ref_q          <= ref_d;
            cnt_q          <= cnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            lockup_q       <= lockup_d;
            step_prev_q    <= step;
        end
    end

    assign state        = state_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign lockup       = lockup_q;

    // Zero-pad the state up to a whole number of nibbles for the display.
    logic [4*NDIG-1:0] state_pad_c;
    assign state_pad_c = (4*NDIG)'(state_q);

    for (genvar k = 0; k < NDIG; k++) begin : g_dig
        hex7seg u_hex (
            .nib_i (state_pad_c[4*k +: 4]),
            .seg_c (seg[7*k +: 7])
        );
    end

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: an 8-bit default instance and a 4-bit instance driven
// together, checked every cycle against a behavioural model plus literal vectors.
module tb_lfsr_gen;

    logic        clk = 1'b0;
    logic        rst_n, en, mode, step, load;
    logic [7:0]  lv8, st8, per8;
    logic [3:0]  lv4, st4, per4;
    logic [13:0] seg8;
    logic [6:0]  seg4;
    logic        pv8, pv4, lk8, lk4;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lfsr_gen u8 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .step(step),
        .load(load), .load_val(lv8), .state(st8), .seg(seg8),
        .period(per8), .period_valid(pv8), .lockup(lk8)
    );

    lfsr_gen #(.WIDTH(4), .TAPS(4'b0011), .SEED(4'h1)) u4 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .step(step),
        .load(load), .load_val(lv4), .state(st4), .seg(seg4),
        .period(per4), .period_valid(pv4), .lockup(lk4)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    // Parity of tapped bits shifted in at the top.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s, input logic [31:0] taps, input int w);
        logic p;
        p = 1'b0;
        for (int i = 0; i < w; i++) if (taps[i] && s[i]) p = ~p;
        return (s >> 1) | (32'(p) << (w - 1));
    endfunction

    function automatic int wid(input int d);
        return (d == 0) ? 8 : 4;
    endfunction

    function automatic logic [31:0] tapm(input int d);
        return (d == 0) ? 32'h1D : 32'h3;
    endfunction

    function automatic logic [31:0] lvof(input int d, input logic [7:0] a, input logic [3:0] b);
        return (d == 0) ? 32'(a) : 32'(b);
    endfunction

    // Model: index 0 = 8-bit instance, index 1 = 4-bit instance.
    logic [31:0] m_state [2];
    logic [31:0] m_ref   [2];
    logic [31:0] m_per   [2];
    int unsigned m_cnt   [2];
    logic        m_pv    [2];
    logic        m_lock  [2];
    logic        m_stp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_stp <= 1'b0;
            for (int d = 0; d < 2; d++) begin
                m_state[d] <= 32'd1;
                m_ref[d]   <= 32'd1;
                m_per[d]   <= 32'd0;
                m_cnt[d]   <= 0;
                m_pv[d]    <= 1'b0;
                m_lock[d]  <= 1'b0;
            end
        end else begin
            m_stp <= step;
            for (int d = 0; d < 2; d++) begin
                m_lock[d] <= 1'b0;
                if (load) begin
                    m_state[d] <= (lvof(d, lv8, lv4) == 0) ? 32'd1 : lvof(d, lv8, lv4);
                    m_ref[d]   <= (lvof(d, lv8, lv4) == 0) ? 32'd1 : lvof(d, lv8, lv4);
                    m_cnt[d]   <= 0;
                    m_pv[d]    <= 1'b0;
                    m_lock[d]  <= (lvof(d, lv8, lv4) == 0);
                end else if (m_state[d] == 0) begin
                    m_state[d] <= 32'd1;
                    m_lock[d]  <= 1'b1;
                end else if (en && (!mode || (step && !m_stp))) begin
                    m_state[d] <= lfsr_next(m_state[d], tapm(d), wid(d));
                    if (lfsr_next(m_state[d], tapm(d), wid(d)) == m_ref[d]) begin
                        m_per[d] <= m_cnt[d] + 1;
                        m_pv[d]  <= 1'b1;
                        m_cnt[d] <= 0;
                    end else begin
                        m_cnt[d] <= m_cnt[d] + 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        check("c_state8",  32'(st8),  m_state[0]);
        check("c_period8", 32'(per8), m_per[0]);
        check("c_pv8",     32'(pv8),  32'(m_pv[0]));
        check("c_lock8",   32'(lk8),  32'(m_lock[0]));
        check("c_seg8",    32'(seg8), 32'({glyph(m_state[0][7:4]), glyph(m_state[0][3:0])}));
        check("c_state4",  32'(st4),  m_state[1]);
        check("c_period4", 32'(per4), m_per[1]);
        check("c_pv4",     32'(pv4),  32'(m_pv[1]));
        check("c_lock4",   32'(lk4),  32'(m_lock[1]));
        check("c_seg4",    32'(seg4), 32'(glyph(m_state[1][3:0])));
    end

    localparam logic [7:0] EXP8 [6]  = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h88};
    localparam logic [3:0] EXP4 [15] = '{4'h1, 4'h8, 4'h4, 4'h2, 4'h9, 4'hC, 4'h6, 4'hB,
                                        4'h5, 4'hA, 4'hD, 4'hE, 4'hF, 4'h7, 4'h3};

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; step = 1'b0; load = 1'b0;
        lv8 = 8'h00; lv4 = 4'h0;
        repeat (3) @(negedge clk);
        check("rst_state8",  32'(st8),  32'h01);
        check("rst_period8", 32'(per8), 32'h0);
        check("rst_pv4",     32'(pv4),  32'h0);
        check("rst_lock4",   32'(lk4),  32'h0);

        // Free-run from reset: two full laps of the 4-bit sequence.
        rst_n = 1'b1; en = 1'b1;
        for (int i = 0; i <= 30; i++) begin
            if (i > 0) @(negedge clk);
            if (i <= 5) check("seq8", 32'(st8), 32'(EXP8[i]));
            if (i == 0) check("seg8_01", 32'(seg8), 32'({7'b1000000, 7'b1111001}));
            if (i == 1) check("seg8_80", 32'(seg8), 32'({7'b0000000, 7'b1000000}));
            check("seq4", 32'(st4), 32'(EXP4[i % 15]));
            check("pv4_rise", 32'(pv4), 32'(i >= 15));
            if (i == 15 || i == 30) check("period4", 32'(per4), 32'd15);
        end

        // Nonzero load re-arms the measurement.
        load = 1'b1; lv4 = 4'h5; lv8 = 8'h5A;
        @(negedge clk);
        load = 1'b0;
        check("load4",    32'(st4), 32'h5);
        check("load_pv4", 32'(pv4), 32'h0);
        check("load8",    32'(st8), 32'h5A);
        repeat (15) @(negedge clk);
        check("lap_state4",  32'(st4),  32'h5);
        check("lap_period4", 32'(per4), 32'd15);
        check("lap_pv4",     32'(pv4),  32'h1);

        // Zero load recovers to 1 with a single lockup pulse.
        load = 1'b1; lv4 = 4'h0; lv8 = 8'h00;
        @(negedge clk);
        load = 1'b0;
        check("zl_state4", 32'(st4), 32'h1);
        check("zl_lock4",  32'(lk4), 32'h1);
        check("zl_state8", 32'(st8), 32'h1);
        check("zl_lock8",  32'(lk8), 32'h1);
        @(negedge clk);
        check("zl_lock_off4", 32'(lk4), 32'h0);
        check("zl_next4",     32'(st4), 32'h8);
        check("zl_next8",     32'(st8), 32'h80);

        // Step mode.
        mode = 1'b1;
        @(negedge clk);
        check("mode1_idle", 32'(st4), 32'h8);
        step = 1'b1;
        repeat (10) @(negedge clk);
        check("step_held", 32'(st4), 32'h4);
        step = 1'b0; en = 1'b0;
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        check("step_en0", 32'(st4), 32'h4);
        step = 1'b0; en = 1'b1;
        @(negedge clk);
        check("step_low", 32'(st4), 32'h4);
        load = 1'b1; lv4 = 4'hC; lv8 = 8'h33; step = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("load_step4", 32'(st4), 32'hC);
        check("load_step8", 32'(st8), 32'h33);
        @(negedge clk);
        check("load_step_hold", 32'(st4), 32'hC);
        mode = 1'b0;
        @(negedge clk);
        check("free_step_high", 32'(st4), 32'h6);
        mode = 1'b1;
        repeat (3) @(negedge clk);
        check("enter_mode1_high", 32'(st4), 32'h6);

        // Asynchronous reset in the middle of a run.
        mode = 1'b0; step = 1'b0;
        repeat (7) @(negedge clk);
        check("pre_rst_state4",  32'(st4),  32'h7);
        check("pre_rst_period4", 32'(per4), 32'd15);
        #3 rst_n = 1'b0;
        #1;
        check("arst_state4",  32'(st4),  32'h1);
        check("arst_period4", 32'(per4), 32'h0);
        check("arst_pv4",     32'(pv4),  32'h0);
        check("arst_state8",  32'(st8),  32'h01);
        check("arst_pv8",     32'(pv8),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised Fibonacci LFSR with runtime seed load, free-run/single-step modes, all-zero lock-up recovery, hardware period measurement and hex 7-segment readout of the state. It is the general-width successor to the fixed 8-bit board LFSR demo. It drives the board's seven-segment digits and exposes state and period to the rest of the design.

## Interface
- `WIDTH`, default 8: LFSR state width, legal range 3..32.
- `TAPS`, default `8'b0001_1101`: feedback mask, WIDTH bits. Bit i set means state[i] is XORed into the feedback bit.
- `SEED`, default 1: nonzero reset and reference value, WIDTH bits.
- `NDIG`, default ceil(WIDTH/4): number of hex digits displayed (derived, not overridden).
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `en`, input, 1: global advance enable.
- `mode`, input, 1: 0 = free-run (advance every enabled cycle), 1 = step (advance on a `step` rising edge).
- `step`, input, 1: step request, already synchronised and debounced by the caller.
- `load`, input, 1: load `load_val` into the state and the reference.
- `load_val`, input, WIDTH: value to load.
- `state`, output, WIDTH: current LFSR state.
- `seg`, output, 7*NDIG: active-low segments. Digit k occupies [7k+6:7k] and shows state nibble k; bit 0 = a … bit 6 = g.
- `period`, output, WIDTH: last measured cycle length.
- `period_valid`, output, 1: `period` holds a measurement since the last load/reset.
- `lockup`, output, 1: one-cycle pulse when the all-zero state was recovered.

## Operation
- Feedback: fb = XOR-reduce(state & TAPS). Advance: state <= {fb, state[WIDTH-1:1]}.
- Advance condition `adv`:
  - mode 0: `adv` = en.
  - mode 1: `adv` = en & step & ~step_d, where step_d is a registered copy of `step` (reset 0).
- Per-edge priority, highest first:
  1. **load**: state <= (load_val==0 ? 1 : load_val). ref <= same value. Counter <= 0. period_valid <= 0. lockup pulses if load_val==0.
  2. **state==0**: state <= 1. lockup <= 1. Counter unchanged. This applies regardless of `adv`.
  3. **adv**: state advances and counter <= counter+1. If the next state equals ref: period <= counter+1, period_valid <= 1, counter <= 0.
  4. Otherwise hold.
- Counter: WIDTH bits. It saturates at all-ones and never wraps. If it saturates, period_valid stays at its current value until the next return to ref.
- period_valid stays set across later periods. `period` updates at every return to ref.
- `seg`: purely combinational from `state`. Nibbles above WIDTH are zero-padded. Hex glyphs 0–F use the standard pattern; for example, 0 = 7'b1000000 and 1 = 7'b1111001.
- Mode changes take effect on the next edge. Switching into mode 1 while `step` is held high does not generate a step.

## Timing
- Reset (async assert, sync-free release): state = SEED, ref = SEED, counter = 0, period = 0, period_valid = 0, lockup = 0, step_d = 0.
- Outputs `state`, `period`, `period_valid`, `lockup` are registered. `seg` follows `state` combinationally, with 0 added cycles.
- Latency: load_val appears on `state` one edge after `load`. Step mode advances on the edge following the `step` rise.
- Reset asserted mid-sequence aborts the measurement immediately. There is no partial-period output.
- load and adv in the same cycle: load wins and no advance occurs.

## Structure
- Package `lfsr_pkg` holds:
  - function `ndig(width)`;
  - the 16-entry active-low hex glyph constant;
  - the default TAPS constants for common widths (4: `4'b0011`, 8: `8'b0001_1101`).
- Sub-module `hex7seg` (4-bit in, 7-bit active-low out) is instantiated NDIG times by a generate loop.
- The core register, priority logic and period counter live in `lfsr_gen`.

## Test plan
- **Reset/advance, defaults:** release rst_n, mode 0, en=1 → state 0x01, 0x80, 0x40, 0x20, 0x10, 0x88 on successive edges; seg[13:0] shows "01" then "80".
- **Period, WIDTH=4, TAPS=4'b0011, SEED=1:** free-run → state visits 1,8,4,2,9,C,6,B,5,A,D,E,F,7,3,1; period_valid rises with state==1 after 15 advances; period=15; value holds across a second lap.
- **Load:** load=1, load_val=0x5 (WIDTH=4) → state=5 next edge, period_valid=0; after 15 advances state=5, period=15, period_valid=1.
- **Zero load:** load_val=0 → state=1, lockup high exactly one cycle; next advance gives 8.
- **Step mode:** mode=1, hold step high 10 cycles → exactly one advance; en=0 with step pulse → no advance; load concurrent with step rise → loaded value, no advance.
- **Reset mid-run:** assert rst_n low after 7 advances → state=SEED, period=0, period_valid=0 asynchronously, before the next clock edge.
